// File: rtl/regfile_mp.sv
// Multi-port integer register file with registered reads and a busy scoreboard.
// Optional `REGFILE_BYPASS_EN forwards same-cycle write data to read ports.
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2,
  parameter int AW        = $clog2(NUM_REGS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_READ-1:0]       rd_en,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*XLEN-1:0]  rd_data,
  output logic [NUM_READ-1:0]       rd_busy,
  input  logic [NUM_WRITE-1:0]      wr_en,
  input  logic [NUM_WRITE*AW-1:0]   wr_addr,
  input  logic [NUM_WRITE*XLEN-1:0] wr_data,
  input  logic                      issue_en,
  input  logic [AW-1:0]             issue_rd
);

  logic [XLEN-1:0]          regs [NUM_REGS];
  logic [NUM_REGS-1:0]      busy;
  logic [NUM_REGS-1:0]      wr_hit;
  logic [NUM_REGS-1:0]      busy_cleared;
  logic [NUM_REGS-1:0]      busy_next;
  logic [NUM_READ*XLEN-1:0] rd_data_next;
  logic [NUM_READ-1:0]      rd_busy_next;

  // Registers hit by an enabled write this cycle; x0 never counts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_hit = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
        wr_hit[wr_addr[w*AW +: AW]] = 1'b1;
      end
    end
  end

  assign busy_cleared = busy & ~wr_hit;

  // Issue applied after the clears, so a same-cycle new producer keeps the bit set.
  always_comb begin
    busy_next = busy_cleared;
    if (issue_en && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
  end

  always_comb begin
    rd_data_next = '0;
    rd_busy_next = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      rd_data_next[p*XLEN +: XLEN] = regs[rd_addr[p*AW +: AW]];
      rd_busy_next[p]              = busy_cleared[rd_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW]) &&
            (rd_addr[p*AW +: AW] != '0)) begin
          rd_data_next[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
        end
      end
`endif
    end
  end

  // NOTE: the storage array is reset on purpose: reset must clear every register at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      // NOTE: non-blocking writes in ascending port order let the highest port win a collision.
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
        end
      end
      busy <= busy_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      for (int p = 0; p < NUM_READ; p++) begin
        if (rd_en[p]) begin
          rd_data[p*XLEN +: XLEN] <= rd_data_next[p*XLEN +: XLEN];
          rd_busy[p]              <= rd_busy_next[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: array-based reference model compared every
// cycle, plus hand-computed literal checks for the directed scenarios.
module tb_regfile_mp;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_rd = '0;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  logic [31:0] m_regs [32];
  logic        m_busy [32];
  logic [31:0] m_rd_data [2];
  logic        m_rd_busy [2];

  regfile_mp dut (
    .clock    (clock),
    .reset    (reset),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .issue_en (issue_en),
    .issue_rd (issue_rd)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      m_rd_data[p] = '0;
      m_rd_busy[p] = 1'b0;
    end
  endtask

  always @(negedge reset) model_clear();

  // Reference model: reads see pre-edge storage (or forwarded data), then writes, then scoreboard.
  always @(posedge clock) begin
    if (reset === 1'b1) begin
      for (int p = 0; p < 2; p++) begin
        if (rd_en[p]) begin
          int a;
          logic [31:0] v;
          bit written;
          a = int'(rd_addr[p*5 +: 5]);
          v = m_regs[a];
          written = 1'b0;
          for (int w = 0; w < 2; w++) begin
            if (wr_en[w] && int'(wr_addr[w*5 +: 5]) == a && a != 0) begin
              written = 1'b1;
`ifdef REGFILE_BYPASS_EN
              v = wr_data[w*32 +: 32];
`endif
            end
          end
          m_rd_data[p] = v;
          m_rd_busy[p] = m_busy[a] && !written;
        end
      end
      for (int w = 0; w < 2; w++) begin
        if (wr_en[w] && wr_addr[w*5 +: 5] != 0) begin
          m_regs[wr_addr[w*5 +: 5]] = wr_data[w*32 +: 32];
          m_busy[wr_addr[w*5 +: 5]] = 1'b0;
        end
      end
      if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (cmp_en && reset === 1'b1) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("model rd_data[%0d]", p), rd_data[p*32 +: 32], m_rd_data[p]);
        check($sformatf("model rd_busy[%0d]", p), {31'b0, rd_busy[p]}, {31'b0, m_rd_busy[p]});
      end
    end
  end

  task automatic step(input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                      input logic [31:0] wd0, input logic [31:0] wd1,
                      input logic ie, input logic [4:0] ir);
    rd_en    = re;
    rd_addr  = {ra1, ra0};
    wr_en    = we;
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    issue_en = ie;
    issue_rd = ir;
    @(negedge clock);
  endtask

  task automatic idle();
    step(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    #1 reset = 1'b0;
    #2;
    check("reset rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
    check("reset rd_busy", {30'b0, rd_busy}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset  = 1'b1;
    cmp_en = 1'b1;

    // Fill r1..r31 (r0 write is ignored) with A5A5_0000 + r.
    for (int r = 0; r < 32; r += 2) begin
      step(2'b00, 5'd0, 5'd0, 2'b11, 5'(r), 5'(r + 1),
           32'hA5A5_0000 + 32'(r), 32'hA5A5_0000 + 32'(r + 1), 1'b0, 5'd0);
    end
    step(2'b11, 5'd5, 5'd31, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd12);
    check("fill r5", rd_data[31:0], 32'hA5A5_0005);
    check("fill r31", rd_data[63:32], 32'hA5A5_001F);

    // Asynchronous reset in the middle of a write cycle.
    rd_en = 2'b11; rd_addr = {5'd5, 5'd6};
    wr_en = 2'b01; wr_addr = {5'd0, 5'd8}; wr_data = {32'h0, 32'h0BAD_0BAD};
    @(posedge clock);
    #2;
    cmp_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("async reset rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
    check("async reset rd_busy", {30'b0, rd_busy}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    idle();
    cmp_en = 1'b1;
    step(2'b11, 5'd5, 5'd8, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    check("post reset r5", rd_data[31:0], 32'h0);
    check("post reset r8", rd_data[63:32], 32'h0);
    check("post reset r12 busy", {30'b0, rd_busy}, 32'h0);

    // Write r3 on port 0, read it on port 1 next cycle.
    step(2'b00, 5'd0, 5'd0, 2'b01, 5'd3, 5'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd0);
    step(2'b10, 5'd0, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    check("write/read r3", rd_data[63:32], 32'hDEAD_BEEF);

    // x0 stays zero and never becomes busy.
    step(2'b00, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd0);
    step(2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    check("x0 data", rd_data[31:0] | rd_data[63:32], 32'h0);
    check("x0 busy", {30'b0, rd_busy}, 32'h0);

    // Write collision on r7 while port 0 reads it.
    step(2'b00, 5'd0, 5'd0, 2'b01, 5'd7, 5'd0, 32'h5, 32'h0, 1'b0, 5'd0);
    step(2'b01, 5'd7, 5'd0, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0);
`ifdef REGFILE_BYPASS_EN
    check("collision forward", rd_data[31:0], 32'h22);
`else
    check("collision old", rd_data[31:0], 32'h5);
`endif
    step(2'b01, 5'd7, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    check("collision after", rd_data[31:0], 32'h22);

    // Scoreboard on r9 and r10.
    step(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9);
    step(2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    check("r9 busy after issue", {31'b0, rd_busy[0]}, 32'h1);
    step(2'b10, 5'd0, 5'd9, 2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 1'b1, 5'd9);
    check("r9 written same cycle reads clear", {31'b0, rd_busy[1]}, 32'h0);
    step(2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    check("r9 busy after write+issue", {31'b0, rd_busy[0]}, 32'h1);
    step(2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 5'd9, 32'h0, 32'h9A, 1'b0, 5'd0);
    step(2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    check("r9 clear after write", {31'b0, rd_busy[0]}, 32'h0);
    check("r9 data", rd_data[31:0], 32'h9A);
    step(2'b01, 5'd10, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd10);
    check("r10 issued same cycle reads prior", {31'b0, rd_busy[0]}, 32'h0);
    step(2'b01, 5'd10, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    check("r10 busy next cycle", {31'b0, rd_busy[0]}, 32'h1);

    // Hold: read r4, then change address with rd_en low.
    step(2'b00, 5'd0, 5'd0, 2'b11, 5'd4, 5'd5, 32'h1234, 32'h5555, 1'b0, 5'd0);
    step(2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    check("hold read r4", rd_data[31:0], 32'h1234);
    step(2'b00, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    check("hold keeps r4", rd_data[31:0], 32'h1234);

    // Mixed directed traffic: collisions, forwarding hits, x0 and issue overlaps.
    for (int i = 0; i < 48; i++) begin
      step(2'(i % 4), 5'((i * 7) % 32), 5'((i * 3 + 1) % 32),
           2'((i + 1) % 4), 5'((i * 5) % 32), 5'((i * 5 + ((i % 3 == 0) ? 0 : 2)) % 32),
           32'(i) * 32'h0101_0101, ~(32'(i) * 32'h0101_0101),
           (i % 3 == 1), 5'((i * 11) % 32));
    end
    for (int r = 0; r < 32; r++) begin
      step(2'b11, 5'(r), 5'(31 - r), 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the wider-issue core. It provides NUM_READ registered read ports and NUM_WRITE write ports, with same-cycle write-to-read forwarding and a per-register busy scoreboard that the decode stage uses to detect RAW hazards. Register x0 is hardwired to zero. The block sits between decode (read and issue) and writeback (write and clear).

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers; must be a power of two, ≥ 2.
- NUM_READ, 2, number of read ports, 1..4.
- NUM_WRITE, 2, number of write ports, 1..2.
- AW, $clog2(NUM_REGS), register address width (derived).

Ports (flattened buses; port p occupies slice [p*W +: W]):
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state while low.
- rd_en  in  NUM_READ  per-port read enable.
- rd_addr  in  NUM_READ*AW  read register indices.
- rd_data  out  NUM_READ*XLEN  registered read data.
- rd_busy  out  NUM_READ  registered scoreboard bit of the register read.
- wr_en  in  NUM_WRITE  per-port write enable.
- wr_addr  in  NUM_WRITE*AW  destination indices.
- wr_data  in  NUM_WRITE*XLEN  write data.
- issue_en  in  1  marks issue_rd busy.
- issue_rd  in  AW  destination of the issuing instruction.

## Operation
- Storage: NUM_REGS × XLEN. x0 always reads 0. Writes and issues to x0 are ignored.
- Write: on a clock edge with wr_en[w]=1, regs[wr_addr[w]] <= wr_data[w]. If two ports target the same register, the higher port index wins.
- Read: on a clock edge with rd_en[p]=1, rd_data[p] and rd_busy[p] load from rd_addr[p]. With rd_en[p]=0, both hold their previous values.
- Scoreboard: busy[r] is set on issue_en with issue_rd=r. It is cleared by any enabled write to r. If issue and clearing write target the same r in the same cycle, busy stays 1 (the new producer wins).
- Read busy path: rd_busy reflects busy after that cycle's clears but before that cycle's sets. A register written this cycle reads not-busy; a register issued this cycle reads its prior state.
- Forwarding: see Configuration.

## Timing
- Read latency: 1 cycle. The address presented in cycle N gives data valid after edge N+1.
- Write visible in storage after the edge. Without forwarding, visible to reads sampled at the following edge.
- Reset (reset=0, asynchronous): all registers, busy bits, rd_data and rd_busy are 0 immediately.
- Deassertion is synchronised externally.
- Reset mid-operation discards in-flight writes and issues of that cycle.
- No back-pressure: every enabled write is accepted every cycle.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read port whose address matches an enabled same-cycle write (non-x0) captures wr_data directly.
  - If multiple writes match, the highest port index is forwarded, consistent with write priority.
- REGFILE_BYPASS_EN undefined:
  - Reads return the pre-write storage value (read-before-write).
  - Decode must stall one extra cycle on a writeback collision.
- The rd_busy semantics are identical in both builds.

## Test plan
- Reset: write regs 1..31 with 0xA5A5_0000+r, pull reset low mid-cycle -> all rd_data=0, rd_busy=0 at once; reading r5 after release gives 0.
- Write/read: write r3=0xDEADBEEF on port 0, read r3 on port 1 next cycle -> rd_data[1]=0xDEADBEEF one cycle after rd_en.
- x0: write x0=0xFFFFFFFF on both ports and issue x0 -> reading x0 gives 0, rd_busy=0.
- Collision: port 0 writes r7=0x11, port 1 writes r7=0x22 in the same cycle while port 0 reads r7:
  - with REGFILE_BYPASS_EN: rd_data[0]=0x22;
  - without: old value, then 0x22 on the next read.
- Scoreboard: issue r9 -> read gives busy=1; write r9 and issue r9 in the same cycle -> busy stays 1; a later write r9 alone -> busy=0.
- Hold: read r4=0x1234, change rd_addr to r5 with rd_en=0 -> rd_data stays 0x1234.
